// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
// Holds register count, ID and counter widths, the counter ceiling, and an ID decoder.
// Imported by the interface, the per-register counter and the top.
package reg_scoreboard_pkg;

    localparam int NREG = 8;  // architectural registers tracked
    localparam int IDW  = 3;  // register ID width
    localparam int CW   = 2;  // per-register pending-counter width

    typedef logic [IDW-1:0] reg_id_t;
    typedef logic [CW-1:0]  cnt_t;

    // Largest number of writes that may be in flight to one register.
    localparam cnt_t CNT_MAX = '1;

    // One-hot decode of a register ID into a per-register strobe vector.
    function automatic logic [NREG-1:0] id_dec(input reg_id_t id);
        return NREG'(1) << id;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/flush bundle between the pipeline and the register scoreboard.
// master: decode/writeback side drives requests, sees stall/pending/err.
// slave:  the scoreboard consumes requests and drives stall/pending/err.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic              issue_valid;
    logic              issue_wr;
    reg_id_t           issue_rd;
    logic              rs_valid;
    reg_id_t           rs;
    logic              rt_valid;
    reg_id_t           rt;
    logic              wb_valid;
    reg_id_t           wb_rd;
    logic              flush;
    logic              stall;
    logic [NREG-1:0]   pending;
    logic              err;

    modport master (
        output issue_valid, issue_wr, issue_rd,
        output rs_valid, rs, rt_valid, rt,
        output wb_valid, wb_rd, flush,
        input  stall, pending, err
    );

    modport slave (
        input  issue_valid, issue_wr, issue_rd,
        input  rs_valid, rs, rt_valid, rt,
        input  wb_valid, wb_rd, flush,
        output stall, pending, err
    );

endinterface

// File: rtl/reg_scoreboard_pend_cnt.sv
// Purpose: CW-bit up/down count of in-flight writes to one register; never wraps.
// Latency: count updates on the next rising edge; nz/underflow are combinational from the count.
// Backpressure: none; the caller must not raise inc at CNT_MAX (it is ignored there).
// Ports: clk, rst (async active-low), inc, dec, clr in; cnt, nz, underflow out.
module reg_scoreboard_pend_cnt
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output cnt_t cnt,
    output logic nz,
    output logic underflow
);

    cnt_t cnt_d, cnt_q;
    logic inc_ok, dec_ok;

    always_comb begin
        nz        = (cnt_q != '0);
        inc_ok    = inc && (cnt_q != CNT_MAX);
        dec_ok    = dec && nz;
        // A retire with nothing pending is an error only if flush is not wiping state anyway.
        underflow = dec && !nz && !clr;
        cnt_d     = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Purpose: tracks in-flight register writes; stalls decode on source or saturated-destination hazards.
// Latency: stall is combinational same-cycle; pending/err reflect state one edge after issue/wb.
// Backpressure: stall=1 means the presented issue is not accepted and must be held.
// Ports: clk, rst (async active-low), sb (reg_scoreboard_if.slave: issue/rs/rt/wb/flush in, stall/pending/err out).
// Option: define SCOREBOARD_WB_BYPASS_EN to let a reader pass when the last pending write retires this cycle.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);

    cnt_t            cnt [NREG];
    logic [NREG-1:0] nz;
    logic [NREG-1:0] underflow;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic            full;
    logic            stall;
    logic            accept;
    logic            err_d, err_q;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy[r] = nz[r];
`ifdef SCOREBOARD_WB_BYPASS_EN
            // Register file writes before it reads, so the final retiring write is already visible.
            if (sb.wb_valid && (sb.wb_rd == reg_id_t'(r)) && (cnt[r] == cnt_t'(1))) begin
                busy[r] = 1'b0;
            end
`endif
        end

        full   = sb.issue_wr && (cnt[sb.issue_rd] == CNT_MAX);
        stall  = sb.issue_valid &&
                 ((sb.rs_valid && busy[sb.rs]) ||
                  (sb.rt_valid && busy[sb.rt]) ||
                  full);
        accept = sb.issue_valid && !stall && sb.issue_wr && !sb.flush;

        inc_vec = accept      ? id_dec(sb.issue_rd) : '0;
        dec_vec = sb.wb_valid ? id_dec(sb.wb_rd)    : '0;

        // Sticky until reset; flush deliberately leaves it alone.
        err_d = err_q | (|underflow);
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        reg_scoreboard_pend_cnt u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .clr       (sb.flush),
            .cnt       (cnt[g]),
            .nz        (nz[g]),
            .underflow (underflow[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sb.stall   = stall;
    assign sb.pending = nz;
    assign sb.err     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW hazards, saturation, same-cycle issue/wb,
// flush priority, underflow error and asynchronous mid-run reset.
// Inputs change 1 time unit after a rising edge; outputs are checked mid-cycle.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic wr, input int rd,
                         input logic rsv, input int rs, input logic rtv, input int rt);
        sb_if.issue_valid = v;
        sb_if.issue_wr    = wr;
        sb_if.issue_rd    = reg_id_t'(rd);
        sb_if.rs_valid    = rsv;
        sb_if.rs          = reg_id_t'(rs);
        sb_if.rt_valid    = rtv;
        sb_if.rt          = reg_id_t'(rt);
    endtask

    task automatic wb(input logic v, input int rd);
        sb_if.wb_valid = v;
        sb_if.wb_rd    = reg_id_t'(rd);
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        wb(1'b0, 0);
        sb_if.flush = 1'b0;
    endtask

    // Advance one clock and settle just after the edge; then let combinational logic settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        // ---------------- reset state
        tick();
        settle();
        chk("reset_pending", 32'(sb_if.pending), 32'h00);
        chk("reset_stall",   32'(sb_if.stall),   32'h0);
        chk("reset_err",     32'(sb_if.err),     32'h0);
        rst = 1'b1;
        tick();

        // ---------------- RAW hazard on r3
        issue(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0);
        settle();
        chk("raw_first_issue_stall", 32'(sb_if.stall), 32'h0);
        tick();
        issue(1'b1, 1'b0, 0, 1'b1, 3, 1'b0, 0);
        settle();
        chk("raw_pending_r3", 32'(sb_if.pending), 32'h08);
        chk("raw_rs_stall",   32'(sb_if.stall),   32'h1);
        tick();
        wb(1'b1, 3);
        settle();
`ifdef SCOREBOARD_WB_BYPASS_EN
        chk("raw_wb_cycle_stall", 32'(sb_if.stall), 32'h0);
`else
        chk("raw_wb_cycle_stall", 32'(sb_if.stall), 32'h1);
`endif
        tick();
        wb(1'b0, 0);
        settle();
        chk("raw_after_wb_stall",   32'(sb_if.stall),   32'h0);
        chk("raw_after_wb_pending", 32'(sb_if.pending), 32'h00);
        tick();

        // ---------------- rt hazard on r0 (no hardwired zero), valid gating
        issue(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 0);
        tick();
        issue(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0);
        settle();
        chk("rt_r0_stall", 32'(sb_if.stall), 32'h1);
        issue(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        settle();
        chk("rt_invalid_no_stall", 32'(sb_if.stall), 32'h0);
        issue(1'b0, 1'b0, 0, 1'b1, 0, 1'b1, 0);
        settle();
        chk("no_issue_no_stall", 32'(sb_if.stall), 32'h0);
        tick();
        chk("wr0_stalled_nochange", 32'(sb_if.pending), 32'h01);
        idle();
        wb(1'b1, 0);
        tick();
        wb(1'b0, 0);
        settle();
        chk("r0_drained", 32'(sb_if.pending), 32'h00);

        // ---------------- saturation on r5
        issue(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("sat_write%0d_stall", i), 32'(sb_if.stall), 32'h0);
            tick();
        end
        settle();
        chk("sat_full_stall",   32'(sb_if.stall),   32'h1);
        chk("sat_full_pending", 32'(sb_if.pending), 32'h20);
        tick();
        settle();
        chk("sat_still_full", 32'(sb_if.stall), 32'h1);
        issue(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        wb(1'b1, 5);
        tick();
        wb(1'b0, 0);
        issue(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0);
        settle();
        chk("sat_after_wb_accept", 32'(sb_if.stall), 32'h0);
        tick();
        settle();
        chk("sat_refull_stall", 32'(sb_if.stall), 32'h1);
        idle();
        wb(1'b1, 5);
        repeat (3) tick();
        wb(1'b0, 0);
        settle();
        chk("sat_drained",     32'(sb_if.pending), 32'h00);
        chk("sat_drained_err", 32'(sb_if.err),     32'h0);

        // ---------------- same-cycle issue and wb on r2
        issue(1'b1, 1'b1, 2, 1'b0, 0, 1'b0, 0);
        tick();
        wb(1'b1, 2);
        settle();
        chk("same_cycle_stall", 32'(sb_if.stall), 32'h0);
        tick();
        idle();
        settle();
        chk("same_cycle_pending", 32'(sb_if.pending), 32'h04);
        wb(1'b1, 2);
        tick();
        wb(1'b0, 0);
        settle();
        chk("same_cycle_cnt_was_1", 32'(sb_if.pending), 32'h00);
        chk("same_cycle_err",       32'(sb_if.err),     32'h0);

        // ---------------- flush priority
        issue(1'b1, 1'b1, 1, 1'b0, 0, 1'b0, 0);
        tick();
        tick();
        issue(1'b1, 1'b1, 6, 1'b0, 0, 1'b0, 0);
        tick();
        idle();
        settle();
        chk("flush_pre_pending", 32'(sb_if.pending), 32'h42);
        issue(1'b1, 1'b1, 4, 1'b0, 0, 1'b0, 0);
        wb(1'b1, 6);
        sb_if.flush = 1'b1;
        tick();
        idle();
        settle();
        chk("flush_pending", 32'(sb_if.pending), 32'h00);
        chk("flush_err",     32'(sb_if.err),     32'h0);

        // ---------------- underflow on r7
        wb(1'b1, 7);
        settle();
        chk("underflow_err_not_yet", 32'(sb_if.err), 32'h0);
        tick();
        wb(1'b0, 0);
        settle();
        chk("underflow_err",     32'(sb_if.err),     32'h1);
        chk("underflow_pending", 32'(sb_if.pending), 32'h00);
        sb_if.flush = 1'b1;
        tick();
        sb_if.flush = 1'b0;
        tick();
        settle();
        chk("err_sticky_over_flush", 32'(sb_if.err), 32'h1);

        // ---------------- asynchronous reset mid-run with cnt[3]=2
        issue(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0);
        tick();
        tick();
        issue(1'b1, 1'b0, 0, 1'b1, 3, 1'b0, 0);
        settle();
        chk("prereset_pending", 32'(sb_if.pending), 32'h08);
        chk("prereset_stall",   32'(sb_if.stall),   32'h1);
        rst = 1'b0;
        #1;
        chk("async_reset_pending", 32'(sb_if.pending), 32'h00);
        chk("async_reset_stall",   32'(sb_if.stall),   32'h0);
        chk("async_reset_err",     32'(sb_if.err),     32'h0);
        idle();
        tick();
        rst = 1'b1;
        tick();
        settle();
        chk("post_reset_pending", 32'(sb_if.pending), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
